// File: rtl/echo_pkg.sv
// Shared constants for the echo request path: message tags, header field
// positions, pipe message word indices and deserializer state codes.
package echo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MSG_WORDS  = 6;

  localparam logic [7:0] TAG_SAY  = 8'd1;
  localparam logic [7:0] TAG_SAY2 = 8'd2;

  localparam int HDR_TAG_LSB   = 0;
  localparam int HDR_LEN_LSB   = 8;
  localparam int HDR_FIELD_W   = 8;

  localparam int WORD_TAG  = 0;
  localparam int WORD_METH = 1;
  localparam int WORD_V    = 2;

  localparam logic [0:0] STATE_HDR = 1'b0;
  localparam logic [0:0] STATE_PAY = 1'b1;

  // A tag is deliverable only if the dispatcher knows how to route it.
  function automatic logic is_known_tag(input logic [7:0] tag);
    return (tag == TAG_SAY) || (tag == TAG_SAY2);
  endfunction

endpackage

// File: rtl/echo_request_deserializer.sv
// Assembles framed 32-bit host beats into 192-bit pipe messages. One frame
// can assemble while the previous message waits in the output register.
module echo_request_deserializer
  import echo_pkg::*;
#(
  parameter int DATA_WIDTH = echo_pkg::DATA_WIDTH,
  parameter int MSG_WORDS  = echo_pkg::MSG_WORDS,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            in_enq__ENA,
  input  logic [DATA_WIDTH-1:0]           in_enq_v,
  output logic                            in_enq__RDY,
  output logic                            pipe_enq__ENA,
  output logic [DATA_WIDTH*MSG_WORDS-1:0] pipe_enq_v,
  input  logic                            pipe_enq__RDY,
  output logic [ERR_WIDTH-1:0]            err_count
);

  localparam int CNT_W = $clog2(MSG_WORDS);
  localparam int MSG_W = DATA_WIDTH * MSG_WORDS;
  localparam int PAY_W = DATA_WIDTH * (MSG_WORDS - 1);

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       frame_len;
  logic [7:0]             frame_tag;
  logic [PAY_W-1:0]       asm_payload;
  logic [MSG_W-1:0]       out_msg;
  logic                   out_valid;

  logic                   last_beat;
  logic                   beat_fire;
  logic                   frame_done;
  logic                   load_out;
  logic                   hdr_len_ok;
  logic                   err_inc;
  logic [HDR_FIELD_W-1:0] hdr_len;
  logic [MSG_W-1:0]       next_msg;

  // Handshake and frame-event decode; input readiness never looks at beat data.
  always_comb begin
    hdr_len    = in_enq_v[HDR_LEN_LSB +: HDR_FIELD_W];
    hdr_len_ok = (hdr_len != '0) && (hdr_len <= HDR_FIELD_W'(MSG_WORDS - 1));
    last_beat  = (state == STATE_PAY) && (cnt == frame_len);
    in_enq__RDY = !(last_beat && out_valid && !pipe_enq__RDY);
    beat_fire  = in_enq__ENA && in_enq__RDY;
    frame_done = beat_fire && last_beat;
    load_out   = frame_done && is_known_tag(frame_tag);
    err_inc    = beat_fire && (((state == STATE_HDR) && !hdr_len_ok) ||
                               (last_beat && !is_known_tag(frame_tag)));
  end

  // Completed message image: the final payload beat is merged in directly so it
  // can be loaded into the output register on the same edge it arrives.
  always_comb begin
    next_msg = '0;
    next_msg[WORD_TAG*DATA_WIDTH +: DATA_WIDTH] = {{(DATA_WIDTH-8){1'b0}}, frame_tag};
    for (int k = 1; k < MSG_WORDS; k++) begin
      if (CNT_W'(k) == cnt)
        next_msg[k*DATA_WIDTH +: DATA_WIDTH] = in_enq_v;
      else
        next_msg[k*DATA_WIDTH +: DATA_WIDTH] = asm_payload[(k-1)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Header/payload sequencer that collects payload words into the assembly buffer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= STATE_HDR;
      cnt         <= '0;
      frame_len   <= '0;
      frame_tag   <= '0;
      asm_payload <= '0;
    end else if (beat_fire) begin
      case (state)
        STATE_HDR: begin
          if (hdr_len_ok) begin
            frame_tag   <= in_enq_v[HDR_TAG_LSB +: 8];
            frame_len   <= hdr_len[CNT_W-1:0];
            cnt         <= CNT_W'(1);
            asm_payload <= '0;
            state       <= STATE_PAY;
          end
        end
        STATE_PAY: begin
          for (int k = 1; k < MSG_WORDS; k++) begin
            if (CNT_W'(k) == cnt)
              asm_payload[(k-1)*DATA_WIDTH +: DATA_WIDTH] <= in_enq_v;
          end
          if (cnt == frame_len)
            state <= STATE_HDR;
          else
            cnt <= cnt + CNT_W'(1);
        end
        default: state <= STATE_HDR;
      endcase
    end
  end

  // One-entry output slot: a newly completed good frame takes priority over
  // emptying, so back-to-back messages leave no bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_msg   <= '0;
      out_valid <= 1'b0;
    end else if (load_out) begin
      out_msg   <= next_msg;
      out_valid <= 1'b1;
    end else if (out_valid && pipe_enq__RDY) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of dropped frames; it sticks at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      err_count <= '0;
    else if (err_inc && (err_count != '1))
      err_count <= err_count + ERR_WIDTH'(1);
  end

  assign pipe_enq__ENA = out_valid;
  assign pipe_enq_v    = out_msg;

endmodule

// File: tb/tb_echo_request_deserializer.sv
// Self-checking bench for echo_request_deserializer: directed scenarios plus
// randomized frame streaming against a queue-based message model.
module tb_echo_request_deserializer;

  localparam int DW   = 32;
  localparam int MW   = 6;
  localparam int MSGW = DW * MW;

  logic            CLK = 1'b0;
  logic            nRST = 1'b0;
  logic            in_ena = 1'b0;
  logic [DW-1:0]   in_v = '0;
  logic            in_rdy;
  logic            pipe_ena;
  logic [MSGW-1:0] pipe_v;
  logic            pipe_rdy = 1'b1;
  logic [15:0]     err_count;

  int tests_run = 0;
  int tests_failed = 0;
  int stall_cycles = 0;

  logic [MSGW-1:0] exp_q[$];
  logic [MSGW-1:0] mon_exp;
  logic [15:0]     exp_err = '0;

  echo_request_deserializer dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .pipe_enq__ENA(pipe_ena),
    .pipe_enq_v   (pipe_v),
    .pipe_enq__RDY(pipe_rdy),
    .err_count    (err_count)
  );

  always #5 CLK = ~CLK;

  // Output monitor: a transfer is seen mid-cycle and compared with the model queue.
  always @(negedge CLK) begin
    if (nRST && pipe_ena && pipe_rdy) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_msg got=%h expected=none", pipe_v);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pipe_v !== mon_exp) begin
          tests_failed++;
          $display("[TB] FAIL msg_data got=%h expected=%h", pipe_v, mon_exp);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [MSGW-1:0] make_msg(input logic [7:0] tag, input int n,
                                               input logic [159:0] pay);
    logic [MSGW-1:0] m;
    m = '0;
    m[7:0] = tag;
    for (int i = 0; i < n; i++) m[32*(i+1) +: 32] = pay[32*i +: 32];
    return m;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    bit acc;
    acc = 0;
    in_ena = 1'b1;
    in_v = d;
    for (int c = 0; c < 100 && !acc; c++) begin
      @(negedge CLK);
      if (in_rdy) acc = 1; else stall_cycles++;
      @(posedge CLK); #1;
    end
    in_ena = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL beat_accept got=timeout expected=accepted beat=%h", d);
    end
  endtask

  task automatic send_frame(input logic [7:0] tag, input logic [7:0] n,
                            input logic [159:0] pay, input logic [15:0] upper);
    bit len_ok;
    len_ok = (n >= 1) && (n <= 5);
    if (len_ok && (tag == 8'd1 || tag == 8'd2)) exp_q.push_back(make_msg(tag, int'(n), pay));
    else if (exp_err != 16'hFFFF) exp_err++;
    send_beat({upper, n, tag});
    if (len_ok)
      for (int i = 0; i < int'(n); i++) send_beat(pay[32*i +: 32]);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
      @(posedge CLK); #1;
    end
    repeat (3) begin @(posedge CLK); #1; end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s_drain got=%0d pending expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    tests_run++;
    if (pipe_ena !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ena got=%b expected=0", pipe_ena); end
    tests_run++;
    if (pipe_v !== '0) begin tests_failed++; $display("[TB] FAIL reset_data got=%h expected=0", pipe_v); end
    tests_run++;
    if (err_count !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_err got=%h expected=0", err_count); end
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_rdy got=%b expected=1", in_rdy); end
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_err = '0;
  endtask

  task automatic test_single_frame();
    pipe_rdy = 1'b1;
    send_frame(8'h01, 8'h02, {128'h0, 32'hB, 32'hA}, 16'h0);
    wait_drain("single");
    tests_run++;
    if (err_count !== 16'h0) begin tests_failed++; $display("[TB] FAIL single_err got=%h expected=0", err_count); end
  endtask

  task automatic test_backpressure();
    logic [MSGW-1:0] first_msg;
    first_msg = '0;
    first_msg[7:0] = 8'h02;
    first_msg[63:32] = 32'h7;
    pipe_rdy = 1'b0;
    send_frame(8'h02, 8'h01, {128'h0, 32'h0, 32'h7}, 16'h0);
    exp_q.push_back(make_msg(8'h01, 1, {128'h0, 32'h0, 32'h8}));
    send_beat(32'h0000_0101);
    in_ena = 1'b1;
    in_v = 32'h8;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      tests_run++;
      if (in_rdy !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_rdy got=%b expected=0", in_rdy); end
      tests_run++;
      if (pipe_ena !== 1'b1 || pipe_v !== first_msg) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold got=%b/%h expected=1/%h", pipe_ena, pipe_v, first_msg);
      end
      @(posedge CLK); #1;
    end
    pipe_rdy = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (in_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_rdy got=%b expected=1", in_rdy); end
    @(posedge CLK); #1;
    in_ena = 1'b0;
    wait_drain("backpressure");
  endtask

  task automatic test_bad_length();
    send_frame(8'h01, 8'h00, '0, 16'h0);
    send_frame(8'h01, 8'h06, '0, 16'h0);
    tests_run++;
    if (err_count !== exp_err) begin tests_failed++; $display("[TB] FAIL badlen_err got=%h expected=%h", err_count, exp_err); end
    send_frame(8'h01, 8'h01, {128'h0, 32'h0, 32'h5}, 16'h0);
    wait_drain("badlen");
  endtask

  task automatic test_bad_tag();
    send_frame(8'h03, 8'h02, {128'h0, 32'h22, 32'h11}, 16'h0);
    tests_run++;
    if (err_count !== exp_err) begin tests_failed++; $display("[TB] FAIL badtag_err got=%h expected=%h", err_count, exp_err); end
    send_frame(8'h02, 8'h03, {96'h0, 32'h33, 32'h22, 32'h11}, 16'h0);
    wait_drain("badtag");
  endtask

  task automatic test_async_reset();
    pipe_rdy = 1'b0;
    send_frame(8'h01, 8'h01, {128'h0, 32'h0, 32'hC}, 16'h0);
    send_beat(32'h0000_0201);
    send_beat(32'hB);
    #2;
    nRST = 1'b0;
    #1;
    tests_run++;
    if (pipe_ena !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_ena got=%b expected=0", pipe_ena); end
    tests_run++;
    if (pipe_v !== '0) begin tests_failed++; $display("[TB] FAIL async_data got=%h expected=0", pipe_v); end
    tests_run++;
    if (err_count !== 16'h0) begin tests_failed++; $display("[TB] FAIL async_err got=%h expected=0", err_count); end
    exp_q.delete();
    exp_err = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    pipe_rdy = 1'b1;
    send_frame(8'h01, 8'h01, {128'h0, 32'h0, 32'h5}, 16'h0);
    wait_drain("async");
  endtask

  task automatic test_streaming();
    logic [159:0] pay;
    logic [31:0]  r;
    logic [7:0]   tag;
    logic [7:0]   n;
    pipe_rdy = 1'b1;
    stall_cycles = 0;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 5; i++) pay[32*i +: 32] = $urandom;
      r = $urandom;
      tag = (r[0]) ? 8'd2 : 8'd1;
      n = 8'($urandom_range(1, 5));
      send_frame(tag, n, pay, r[31:16]);
    end
    wait_drain("stream");
    tests_run++;
    if (stall_cycles != 0) begin tests_failed++; $display("[TB] FAIL stream_stalls got=%0d expected=0", stall_cycles); end
    tests_run++;
    if (err_count !== exp_err) begin tests_failed++; $display("[TB] FAIL stream_err got=%h expected=%h", err_count, exp_err); end
  endtask

  task automatic test_err_saturation();
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_err = '0;
    exp_q.delete();
    for (int i = 0; i < 65534; i++) send_frame(8'h01, 8'h00, '0, 16'h0);
    tests_run++;
    if (err_count !== 16'hFFFE) begin tests_failed++; $display("[TB] FAIL sat_fffe got=%h expected=fffe", err_count); end
    send_frame(8'h01, 8'h06, '0, 16'h0);
    send_frame(8'h03, 8'h01, {128'h0, 32'h0, 32'h9}, 16'h0);
    send_frame(8'h02, 8'h00, '0, 16'h0);
    tests_run++;
    if (err_count !== 16'hFFFF || exp_err !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL sat_ffff got=%h expected=ffff", err_count);
    end
    wait_drain("sat");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_bad_length();
    test_bad_tag();
    test_async_reset();
    test_streaming();
    test_err_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
